// File: rtl/debug_wb_pkg.sv
// Shared types and constants for the debug Wishbone initiator.
package debug_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int         ERR_CNT_W  = 8;
    localparam logic [3:0] WB_SEL_ALL = 4'hF;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Up-counter measuring how long the current bus cycle has waited for ack.
// expired_o is high during the TIMEOUT-th counted cycle (count == TIMEOUT-1).
module wb_timeout_ctr #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] count_q, count_d;

    // Next count: clear wins over enable.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LAST);

endmodule

// File: rtl/debug_wb_master.sv
// Single-transaction Wishbone initiator driven by a command/response stream.
// Every command gets exactly one response; unacked cycles are aborted after
// TIMEOUT bus cycles and reported with rsp_err, counted in err_cnt.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// BUS   | cyc/stb asserted, waiting for ack or timeout
// RESP  | response presented, waiting for rsp_ready
module debug_wb_master
    import debug_wb_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_we,
    input  logic [31:0]          cmd_adr,
    input  logic [31:0]          cmd_dat,
    input  logic [3:0]           cmd_sel,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_dat,
    output logic                 rsp_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic                 wbm_we_o,
    output logic [3:0]           wbm_sel_o,
    output logic [31:0]          wbm_adr_o,
    output logic [31:0]          wbm_dat_o,
    input  logic [31:0]          wbm_dat_i,
    input  logic                 wbm_ack_i
);

    state_e                 state_q, state_d;
    logic                   cyc_q, cyc_d;
    logic                   we_q, we_d;
    logic [3:0]             sel_q, sel_d;
    logic [31:0]            adr_q, adr_d;
    logic [31:0]            dat_q, dat_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [31:0]            rsp_dat_q, rsp_dat_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic                   tmr_clr, tmr_en, tmr_expired;

    wb_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .clk_i     (wb_clk_i),
        .rst_i     (wb_rst_i),
        .clr_i     (tmr_clr),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );

    // Next-state and datapath: bus outputs are zero whenever cyc is low.
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        err_cnt_d   = err_cnt_q;
        tmr_clr     = 1'b0;
        tmr_en      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cyc_d   = 1'b1;
                    we_d    = cmd_we;
                    sel_d   = cmd_sel;
                    adr_d   = cmd_adr;
                    dat_d   = cmd_dat;
                    tmr_clr = 1'b1;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (wbm_ack_i) begin
                    // Ack takes priority over a coincident timeout.
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    sel_d       = '0;
                    adr_d       = '0;
                    dat_d       = '0;
                    rsp_dat_d   = we_q ? 32'd0 : wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_expired) begin
                        cyc_d       = 1'b0;
                        we_d        = 1'b0;
                        sel_d       = '0;
                        adr_d       = '0;
                        dat_d       = '0;
                        rsp_dat_d   = '0;
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        err_cnt_d   = sat_inc(err_cnt_q);
                        state_d     = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any bus cycle or response.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign cmd_ready = (state_q == IDLE) && !wb_rst_i;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;
    assign err_cnt   = err_cnt_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_debug_wb_master.sv
module tb_debug_wb_master;
    import debug_wb_pkg::*;

    localparam int          TIMEOUT = 16;
    localparam logic [31:0] ADR_A   = 32'h3000_0008;
    localparam logic [31:0] ADR_B   = 32'h3000_000C;
    localparam logic [31:0] ADR_X   = 32'h3000_0004;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic [7:0]  err_cnt;
    logic        cyc, stb, we, ack;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o, dat_i;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [31:0] dat;
        logic        err;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    debug_wb_master #(.TIMEOUT(TIMEOUT), .TO_W(16)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .err_cnt   (err_cnt),
        .wbm_cyc_o (cyc),
        .wbm_stb_o (stb),
        .wbm_we_o  (we),
        .wbm_sel_o (sel),
        .wbm_adr_o (adr),
        .wbm_dat_o (dat_o),
        .wbm_dat_i (dat_i),
        .wbm_ack_i (ack)
    );

    // Registered responder: two word registers, ack after ack_delay strobe cycles.
    logic [31:0] mem [2] = '{32'h0, 32'h0};
    logic        ack_q = 1'b0;
    logic [31:0] rdat_q = '0;
    int          bcnt = 0;
    int          ack_delay = 1;
    logic        stray_ack = 1'b0;
    wire         hit = (adr == ADR_A) || (adr == ADR_B);

    assign ack   = ack_q | stray_ack;
    assign dat_i = rdat_q;

    always @(posedge clk) begin
        if (cyc && stb && !ack_q) begin
            if (hit && (bcnt + 1 >= ack_delay)) begin
                ack_q <= 1'b1;
                bcnt  <= 0;
                if (we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (sel[b]) mem[adr[2]][8*b +: 8] <= dat_o[8*b +: 8];
                    end
                end else begin
                    rdat_q <= mem[adr[2]];
                end
            end else begin
                bcnt <= bcnt + 1;
            end
        end else begin
            ack_q <= 1'b0;
            if (!cyc) bcnt <= 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command; returns in the first cycle after acceptance.
    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        if (!cmd_ready) begin
            n_checks++;
            $display("FAIL cmd_ready_wait: cmd_ready=%b after %0d cycles, expected 1", cmd_ready, n);
        end
        cmd_valid = 1'b1;
        cmd_we    = w;
        cmd_adr   = a;
        cmd_dat   = d;
        cmd_sel   = s;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Returns the cycle number (cycle 1 = first bus cycle) in which rsp_valid is seen.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 200) begin
            tick();
            lat++;
        end
        if (!rsp_valid) begin
            n_checks++;
            $display("FAIL rsp_wait: rsp_valid=%b after %0d cycles, expected 1", rsp_valid, lat);
        end
    endtask

    task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd, output logic er,
                           output int lat);
        send_cmd(w, a, d, s);
        wait_rsp(lat);
        rd = rsp_dat;
        er = rsp_err;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_checks++; if (cyc !== 1'b0 || stb !== 1'b0) $display("FAIL rst_cyc: cyc=%b stb=%b expected 0", cyc, stb); else n_pass++;
        n_checks++; if ({we, sel, adr, dat_o} !== '0) $display("FAIL rst_bus: we=%b sel=%h adr=%h dat=%h expected 0", we, sel, adr, dat_o); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_dat !== 32'd0) $display("FAIL rst_rsp: valid=%b err=%b dat=%h expected 0", rsp_valid, rsp_err, rsp_dat); else n_pass++;
        n_checks++; if (err_cnt !== 8'd0) $display("FAIL rst_errcnt: got %0d expected 0", err_cnt); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready: got %b expected 0", cmd_ready); else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL post_rst_ready: got %b expected 1", cmd_ready); else n_pass++;
    endtask

    task automatic test_write_read();
        exp_t e;
        logic [31:0] rd;
        logic er;
        int lat;
        sb_q.push_back('{dat: 32'h0, err: 1'b0});
        send_cmd(1'b1, ADR_A, 32'hA5A5_1234, WB_SEL_ALL);
        n_checks++; if (cyc !== 1'b1 || stb !== 1'b1) $display("FAIL wr_c1_cycstb: cyc=%b stb=%b expected 1", cyc, stb); else n_pass++;
        n_checks++; if ({we, sel, adr, dat_o} !== {1'b1, 4'hF, ADR_A, 32'hA5A5_1234}) $display("FAIL wr_c1_bus: we=%b sel=%h adr=%h dat=%h", we, sel, adr, dat_o); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b0) $display("FAIL wr_c1_ready: got %b expected 0", cmd_ready); else n_pass++;
        tick();
        n_checks++; if (ack !== 1'b1 || cyc !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL wr_c2: ack=%b cyc=%b rsp_valid=%b expected 1 1 0", ack, cyc, rsp_valid); else n_pass++;
        tick();
        n_checks++; if (rsp_valid !== 1'b1) $display("FAIL wr_c3_valid: got %b expected 1", rsp_valid); else n_pass++;
        e = sb_q.pop_front();
        n_checks++; if (rsp_dat !== e.dat || rsp_err !== e.err) $display("FAIL wr_rsp: dat=%h err=%b expected %h %b", rsp_dat, rsp_err, e.dat, e.err); else n_pass++;
        n_checks++; if ({cyc, stb, we, sel, adr, dat_o} !== '0) $display("FAIL wr_c3_bus_idle: cyc=%b adr=%h dat=%h sel=%h expected 0", cyc, adr, dat_o, sel); else n_pass++;
        tick();
        n_checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL wr_c4: rsp_valid=%b cmd_ready=%b expected 0 1", rsp_valid, cmd_ready); else n_pass++;

        sb_q.push_back('{dat: 32'hA5A5_1234, err: 1'b0});
        run_txn(1'b0, ADR_A, 32'h0, WB_SEL_ALL, rd, er, lat);
        e = sb_q.pop_front();
        n_checks++; if (lat !== 3) $display("FAIL rd_latency: rsp_valid in cycle %0d expected 3", lat); else n_pass++;
        n_checks++; if (rd !== e.dat || er !== e.err) $display("FAIL rd_data: dat=%h err=%b expected %h %b", rd, er, e.dat, e.err); else n_pass++;
    endtask

    task automatic test_partial_write();
        exp_t e;
        logic [31:0] rd;
        logic er;
        int lat;
        sb_q.push_back('{dat: 32'h0, err: 1'b0});
        run_txn(1'b1, ADR_A, 32'h0000_FF00, 4'b0010, rd, er, lat);
        e = sb_q.pop_front();
        n_checks++; if (rd !== e.dat || er !== e.err) $display("FAIL pw_wr_rsp: dat=%h err=%b expected %h %b", rd, er, e.dat, e.err); else n_pass++;
        sb_q.push_back('{dat: 32'hA5A5_FF34, err: 1'b0});
        run_txn(1'b0, ADR_A, 32'h0, WB_SEL_ALL, rd, er, lat);
        e = sb_q.pop_front();
        n_checks++; if (rd !== e.dat || er !== e.err) $display("FAIL pw_rd_data: dat=%h err=%b expected %h %b", rd, er, e.dat, e.err); else n_pass++;
    endtask

    task automatic test_timeout();
        exp_t e;
        int n = 0;
        sb_q.push_back('{dat: 32'h0, err: 1'b1});
        send_cmd(1'b0, ADR_X, 32'h0, WB_SEL_ALL);
        while (cyc && n < 100) begin
            n++;
            tick();
        end
        n_checks++; if (n !== TIMEOUT) $display("FAIL to_cyc_len: cyc high %0d cycles expected %0d", n, TIMEOUT); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b1) $display("FAIL to_valid: got %b expected 1", rsp_valid); else n_pass++;
        e = sb_q.pop_front();
        n_checks++; if (rsp_dat !== e.dat || rsp_err !== e.err) $display("FAIL to_rsp: dat=%h err=%b expected %h %b", rsp_dat, rsp_err, e.dat, e.err); else n_pass++;
        n_checks++; if (err_cnt !== 8'd1) $display("FAIL to_errcnt: got %0d expected 1", err_cnt); else n_pass++;
        tick();
    endtask

    task automatic test_ack_at_timeout();
        exp_t e;
        logic [31:0] rd;
        logic er;
        int lat;
        int n = 0;
        ack_delay = TIMEOUT - 1;
        sb_q.push_back('{dat: 32'h0, err: 1'b0});
        send_cmd(1'b1, ADR_B, 32'h5EC0_0016, WB_SEL_ALL);
        while (cyc && n < 100) begin
            n++;
            tick();
        end
        e = sb_q.pop_front();
        n_checks++; if (n !== TIMEOUT) $display("FAIL at_cyc_len: cyc high %0d cycles expected %0d", n, TIMEOUT); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== e.err || rsp_dat !== e.dat) $display("FAIL at_rsp: valid=%b err=%b dat=%h expected 1 %b %h", rsp_valid, rsp_err, rsp_dat, e.err, e.dat); else n_pass++;
        n_checks++; if (err_cnt !== 8'd1) $display("FAIL at_errcnt: got %0d expected 1", err_cnt); else n_pass++;
        tick();
        ack_delay = 1;
        sb_q.push_back('{dat: 32'h5EC0_0016, err: 1'b0});
        run_txn(1'b0, ADR_B, 32'h0, WB_SEL_ALL, rd, er, lat);
        e = sb_q.pop_front();
        n_checks++; if (rd !== e.dat || er !== e.err) $display("FAIL at_readback: dat=%h err=%b expected %h %b", rd, er, e.dat, e.err); else n_pass++;
    endtask

    task automatic test_backpressure();
        exp_t e;
        int lat;
        rsp_ready = 1'b0;
        sb_q.push_back('{dat: 32'hA5A5_FF34, err: 1'b0});
        send_cmd(1'b0, ADR_A, 32'h0, WB_SEL_ALL);
        wait_rsp(lat);
        e = sb_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (rsp_valid !== 1'b1 || rsp_dat !== e.dat || rsp_err !== e.err) $display("FAIL bp_hold[%0d]: valid=%b dat=%h err=%b expected 1 %h %b", i, rsp_valid, rsp_dat, rsp_err, e.dat, e.err); else n_pass++;
            n_checks++; if (cmd_ready !== 1'b0 || cyc !== 1'b0 || stb !== 1'b0) $display("FAIL bp_idle[%0d]: cmd_ready=%b cyc=%b stb=%b expected 0", i, cmd_ready, cyc, stb); else n_pass++;
            tick();
        end
        rsp_ready = 1'b1;
        n_checks++; if (rsp_valid !== 1'b1) $display("FAIL bp_still_valid: got %b expected 1", rsp_valid); else n_pass++;
        tick();
        n_checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL bp_after_hs: rsp_valid=%b cmd_ready=%b expected 0 1", rsp_valid, cmd_ready); else n_pass++;
    endtask

    task automatic test_err_saturation();
        exp_t e;
        logic [31:0] rd;
        logic er;
        int lat;
        for (int i = 0; i < 299; i++) begin
            sb_q.push_back('{dat: 32'h0, err: 1'b1});
            run_txn(1'b0, ADR_X, 32'h0, WB_SEL_ALL, rd, er, lat);
            e = sb_q.pop_front();
            n_checks++; if (rd !== e.dat || er !== e.err) $display("FAIL sat_rsp[%0d]: dat=%h err=%b expected %h %b", i, rd, er, e.dat, e.err); else n_pass++;
        end
        n_checks++; if (err_cnt !== 8'd255) $display("FAIL sat_errcnt: got %0d expected 255", err_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [31:0] rd;
        logic er;
        int lat;
        send_cmd(1'b0, ADR_X, 32'h0, WB_SEL_ALL);
        tick();
        tick();
        n_checks++; if (cyc !== 1'b1) $display("FAIL rm_in_bus: cyc=%b expected 1", cyc); else n_pass++;
        rst = 1'b1;
        tick();
        n_checks++; if (cyc !== 1'b0 || stb !== 1'b0 || adr !== 32'd0) $display("FAIL rm_bus: cyc=%b stb=%b adr=%h expected 0", cyc, stb, adr); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b0 || err_cnt !== 8'd0) $display("FAIL rm_rsp: rsp_valid=%b err_cnt=%0d expected 0 0", rsp_valid, err_cnt); else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL rm_ready: got %b expected 1", cmd_ready); else n_pass++;
        stray_ack = 1'b1;
        tick();
        tick();
        stray_ack = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0 || cyc !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL rm_stray_ack: rsp_valid=%b cyc=%b cmd_ready=%b expected 0 0 1", rsp_valid, cyc, cmd_ready); else n_pass++;
        sb_q.push_back('{dat: 32'hA5A5_FF34, err: 1'b0});
        run_txn(1'b0, ADR_A, 32'h0, WB_SEL_ALL, rd, er, lat);
        e = sb_q.pop_front();
        n_checks++; if (rd !== e.dat || er !== e.err || lat !== 3) $display("FAIL rm_recover: dat=%h err=%b lat=%0d expected %h %b 3", rd, er, lat, e.dat, e.err); else n_pass++;
        n_checks++; if (sb_q.size() !== 0) $display("FAIL sb_empty: %0d entries left expected 0", sb_q.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial_write();
        test_timeout();
        test_ack_at_timeout();
        test_backpressure();
        test_err_saturation();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
